ext_mem_arbiter_32: RTL and testbench
=====================================

Name: ext_mem_arbiter_32

Overview:
- Shares the 32-bit external memory port (ext_addr/ext_mem_read/ext_mem_write/ext_mem_enable/ext_mem_ready) between NUM_REQ requesters, e.g. CPU fetch, CPU load/store and DMA.
- Round-robin arbitration, one outstanding access at a time, registered memory-side strobes.
- Sits between the requesters and the system's external memory pins. Tristating of the bidirectional data bus happens outside this block.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 255, ACCESS cycles allowed before abort (only used with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_write  in  NUM_REQ  1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- rsp_valid  out  NUM_REQ  one-hot completion pulse.
- rsp_rdata  out  DATA_W  read data, shared.
- rsp_error  out  1  completion was a timeout abort.
- ext_addr  out  ADDR_W  memory address.
- ext_wdata  out  DATA_W  memory write data.
- ext_rdata  in  DATA_W  memory read data.
- ext_mem_read  out  1  read strobe.
- ext_mem_write  out  1  write strobe.
- ext_mem_enable  out  1  access in progress.
- ext_mem_ready  in  1  memory completes the access.

Behaviour:
- Clocking and reset:
  - Single clock; reset is asynchronous, active-low on rst_n.
  - Reset values: all outputs 0; state=IDLE; last_grant=NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, ACCESS.
- IDLE:
  - If any req_valid is set, pick the first set bit searching upward from last_grant+1, modulo NUM_REQ.
  - Pulse req_ready[g] combinationally in that same cycle.
  - At the clock edge: latch addr, wdata and write; set last_grant=g; go to ACCESS.
  - No request: stay in IDLE, req_ready=0.
- ACCESS:
  - ext_mem_enable=1; ext_mem_read=~wr; ext_mem_write=wr; ext_addr and ext_wdata come from the latched registers and are stable for the whole state.
  - ext_mem_ready is sampled at each rising edge.
  - When it is seen high: register rsp_rdata = wr ? 0 : ext_rdata; pulse rsp_valid[g] for exactly one cycle, the first cycle back in IDLE; return to IDLE.
- Latency:
  - Accept at cycle T; strobes asserted T+1.
  - With ready high at T+1: rsp_valid at T+2.
  - Each memory wait cycle adds one cycle.
- Throughput: IDLE may accept a new request in the same cycle rsp_valid is high. Peak rate is one access per 2 cycles.
- Requester rules:
  - Hold req_valid and payload stable until req_ready.
  - Deasserting before accept is legal and has no effect.
  - A requester may re-request in its own rsp_valid cycle.
- ext_mem_ready is ignored outside ACCESS.
- Strobes drop to 0 in the IDLE cycle after completion; they are never asserted back-to-back without an intervening IDLE cycle.
- Simultaneous requests are served in strict rotation. With all requesters active, each is served once per NUM_REQ grants; no starvation.
- Reset mid-ACCESS: strobes drop immediately (asynchronously). The in-flight access is lost and no rsp_valid is issued; requesters reissue.
- rsp_rdata holds its value until the next completion.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entry to ACCESS and increments each ACCESS cycle while ext_mem_ready=0.
  - Once it reaches TIMEOUT_CYCLES with ready still low: abort to IDLE, pulse rsp_valid[g] with rsp_error=1 and rsp_rdata=0.
  - rsp_error is 0 on every normal completion.
- Undefined: ACCESS waits indefinitely; rsp_error is tied to 0; no counter logic.

Decomposition:
- Package ext_mem_arb_pkg holds: state enum (IDLE, ACCESS); default widths ADDR_W/DATA_W; default TIMEOUT_CYCLES.
- One sub-module, rr_arbiter:
  - Inputs: req vector, last_grant pointer.
  - Outputs: one-hot grant, grant index, any_grant.
  - Purely combinational; the pointer register stays in the parent.

Test Plan:
- Single read: req_valid=01, addr 0x1000; memory returns 0x00002710 with ready high at the first ACCESS cycle. Expect req_ready[0] at T, ext_mem_read/ext_mem_enable high with ext_addr=0x1000 at T+1, rsp_valid[0] with rsp_rdata=10000 at T+2.
- Fairness: both requesters hold req_valid continuously. Expect grant order 0,1,0,1,0,1 over 6 accesses, each grant exactly 2 cycles apart with a zero-wait memory.
- Wait states and write: requester 1 writes 0x0001388 to 0x1004; ready is low for 3 ACCESS cycles. Expect ext_mem_write high with address and data stable for 4 cycles, rsp_valid[1] 1 cycle later, rsp_rdata=0.
- Timeout, with ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: ready held low. Expect strobes drop after 8 ACCESS cycles, rsp_valid[0]=1 with rsp_error=1; the next request proceeds normally with rsp_error=0.
- Reset mid-access: assert rst_n=0 in the 2nd ACCESS cycle. Expect all outputs 0 asynchronously, no rsp_valid; after release, requester 0 wins even when both request.
- Withdrawal: requester 1 raises req_valid for one cycle while an ACCESS is in progress and drops it before IDLE. Expect no req_ready[1] and no memory access for it.

Source files
------------

// File: rtl/ext_mem_arb_pkg.sv
// rtl/ext_mem_arb_pkg.sv - shared state type and default sizes for the external memory arbiter
package ext_mem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_e;

  localparam int DEF_ADDR_W         = 32;
  localparam int DEF_DATA_W         = 32;
  localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, searching upward from last_grant+1
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_grant_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             any_grant_o
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_grant_o = 1'b0;
    idx         = '0;
    // off = N wraps back to last_grant itself, so a lone re-requester still wins
    for (int off = 1; off <= N; off++) begin
      idx = IDX_W'((int'(last_grant_i) + off) % N);
      if (!any_grant_o && req_i[idx]) begin
        any_grant_o  = 1'b1;
        grant_idx_o  = idx;
        grant_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ext_mem_arbiter_32.sv
// rtl/ext_mem_arbiter_32.sv - round-robin arbiter for the shared external memory port; ARB_TIMEOUT_EN adds access timeout abort
module ext_mem_arbiter_32
  import ext_mem_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_error,
  output logic [ADDR_W-1:0]         ext_addr,
  output logic [DATA_W-1:0]         ext_wdata,
  input  logic [DATA_W-1:0]         ext_rdata,
  output logic                      ext_mem_read,
  output logic                      ext_mem_write,
  output logic                      ext_mem_enable,
  input  logic                      ext_mem_ready
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("ext_mem_arbiter_32: parameter out of range");
  end

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wr_q, wr_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [NUM_REQ-1:0]  grant;
  logic [IDX_W-1:0]    grant_idx;
  logic                any_grant;
  logic                tmo;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx),
    .any_grant_o  (any_grant)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;
  logic [CNT_W-1:0] cnt_q;

  // counter holds the number of stalled ACCESS cycles before this one
  assign tmo = (state_q == ACCESS) && !ext_mem_ready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt_q <= '0;
    else if (state_q == IDLE)    cnt_q <= '0;
    else if (!ext_mem_ready)     cnt_q <= cnt_q + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      rsp_valid_q  <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wr_q         <= wr_d;
      rsp_valid_q  <= rsp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wr_d         = wr_q;
    rsp_valid_d  = '0;
    rdata_d      = rdata_q;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_grant) begin
          state_d      = ACCESS;
          last_grant_d = grant_idx;
          addr_d       = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
          wdata_d      = req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
          wr_d         = req_write[grant_idx];
        end
      end
      ACCESS: begin
        if (ext_mem_ready || tmo) begin
          state_d                   = IDLE;
          rsp_valid_d[last_grant_q] = 1'b1;
          rdata_d                   = (wr_q || tmo) ? '0 : ext_rdata;
          err_d                     = tmo;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready      = (state_q == IDLE && rst_n) ? grant : '0;
    ext_mem_enable = (state_q == ACCESS);
    ext_mem_read   = ext_mem_enable & ~wr_q;
    ext_mem_write  = ext_mem_enable & wr_q;
    ext_addr       = addr_q;
    ext_wdata      = wdata_q;
    rsp_valid      = rsp_valid_q;
    rsp_rdata      = rdata_q;
    rsp_error      = err_q;
  end

endmodule

// File: tb/tb_ext_mem_arbiter_32.sv
// tb/tb_ext_mem_arbiter_32.sv - scoreboard bench for ext_mem_arbiter_32
module tb_ext_mem_arbiter_32;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef ARB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, ext_wdata, ext_rdata;
  logic [AW-1:0]   ext_addr;
  logic            rsp_error, ext_mem_read, ext_mem_write, ext_mem_enable, ext_mem_ready;

  ext_mem_arbiter_32 #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_rdata(ext_rdata),
    .ext_mem_read(ext_mem_read), .ext_mem_write(ext_mem_write),
    .ext_mem_enable(ext_mem_enable), .ext_mem_ready(ext_mem_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic push_exp(input int i, input logic [31:0] d, input logic e);
    exp_t x;
    x.idx = i; x.rdata = d; x.err = e;
    sb.push_back(x);
  endtask

  // memory model: data is address + 0x1710, ready after wait_n stalled cycles
  int acc_cnt = 0;
  int wait_n  = 0;
  always @(posedge clk) acc_cnt <= ext_mem_enable ? acc_cnt + 1 : 0;
  assign ext_mem_ready = ext_mem_enable && (acc_cnt >= wait_n);
  assign ext_rdata     = ext_addr + 32'h1710;

  int         cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N-1:0] grant_log[$];
  int           grant_cyc[$];
  int           n_acc = 0;
  logic         en_prev = 1'b0;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (req_ready != '0) begin
        grant_log.push_back(req_ready);
        grant_cyc.push_back(cyc);
      end
      if (ext_mem_enable && !en_prev) n_acc++;
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          check_eq("rsp_unexpected", 32'(rsp_valid), 32'h0);
        end else begin
          mon_e = sb.pop_front();
          check_eq("rsp_valid", 32'(rsp_valid), 32'(1 << mon_e.idx));
          check_eq("rsp_rdata", rsp_rdata, mon_e.rdata);
          check_eq("rsp_error", 32'(rsp_error), 32'(mon_e.err));
        end
      end
    end
    en_prev = ext_mem_enable;
  end

  task automatic after_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int i);
    logic got;
    got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      got = req_ready[i];
    end
    check_eq($sformatf("grant%0d_seen", i), 32'(got), 32'h1);
  endtask

  task automatic drive_reads(input int i, input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      req_addr[i*AW +: AW] = base + 32'(4 * k);
      req_write[i] = 1'b0;
      req_valid[i] = 1'b1;
      wait_grant(i);
      after_pos();
    end
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 30 && sb.size() != 0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_eq("sb_empty", 32'(sb.size()), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_strobes", 32'({ext_mem_enable, ext_mem_read, ext_mem_write, rsp_error}), 32'h0);
    check_eq("rst_ext_addr", ext_addr, 32'h0);
    check_eq("rst_ext_wdata", ext_wdata, 32'h0);
    check_eq("rst_handshake", 32'({rsp_valid, req_ready}), 32'h0);
    check_eq("rst_rdata", rsp_rdata, 32'h0);
    rst_n = 1'b1;

    // single read from requester 0
    after_pos();
    wait_n = 0;
    req_addr[0 +: AW] = 32'h1000; req_valid[0] = 1'b1;
    @(negedge clk);
    check_eq("rd_ready_T", 32'(req_ready), 32'h1);
    push_exp(0, 32'h2710, 1'b0);
    after_pos();
    req_valid[0] = 1'b0;
    @(negedge clk);
    check_eq("rd_strobes_T1", 32'({ext_mem_enable, ext_mem_read, ext_mem_write}), 32'b110);
    check_eq("rd_addr_T1", ext_addr, 32'h1000);
    check_eq("rd_no_rsp_T1", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    check_eq("rd_rsp_T2", 32'(rsp_valid), 32'h1);
    check_eq("rd_enable_T2", 32'(ext_mem_enable), 32'h0);
    @(negedge clk);
    check_eq("rd_rdata_hold", rsp_rdata, 32'h2710);
    check_eq("rd_rsp_pulse", 32'(rsp_valid), 32'h0);

    // write from requester 1 with three wait states
    after_pos();
    wait_n = 3;
    req_addr[AW +: AW] = 32'h1004; req_wdata[DW +: DW] = 32'h0001388;
    req_write[1] = 1'b1; req_valid[1] = 1'b1;
    @(negedge clk);
    check_eq("wr_ready_T", 32'(req_ready), 32'h2);
    push_exp(1, 32'h0, 1'b0);
    after_pos();
    req_valid[1] = 1'b0; req_write[1] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_eq($sformatf("wr_strobes_T%0d", k), 32'({ext_mem_enable, ext_mem_read, ext_mem_write}), 32'b101);
      check_eq($sformatf("wr_addr_T%0d", k), ext_addr, 32'h1004);
      check_eq($sformatf("wr_wdata_T%0d", k), ext_wdata, 32'h0001388);
    end
    @(negedge clk);
    check_eq("wr_rsp_T5", 32'(rsp_valid), 32'h2);
    check_eq("wr_strobe_drop", 32'(ext_mem_write), 32'h0);
    drain();

    // fairness: both requesters hold requests for three reads each
    wait_n = 0;
    for (int k = 0; k < 3; k++) begin
      push_exp(0, 32'h2000 + 32'(4 * k) + 32'h1710, 1'b0);
      push_exp(1, 32'h3000 + 32'(4 * k) + 32'h1710, 1'b0);
    end
    grant_log.delete(); grant_cyc.delete();
    after_pos();
    fork
      drive_reads(0, 3, 32'h2000);
      drive_reads(1, 3, 32'h3000);
    join
    drain();
    check_eq("fair_count", 32'(grant_log.size()), 32'h6);
    for (int k = 0; k < grant_log.size(); k++)
      check_eq($sformatf("fair_order%0d", k), 32'(grant_log[k]), 32'(1 << (k % 2)));
    for (int k = 1; k < grant_cyc.size(); k++)
      check_eq($sformatf("fair_gap%0d", k), 32'(grant_cyc[k] - grant_cyc[k-1]), 32'h2);

    // withdrawal: requester 1 pulses during an access and drops before IDLE
    grant_log.delete(); grant_cyc.delete(); n_acc = 0;
    after_pos();
    wait_n = 2;
    req_addr[0 +: AW] = 32'h4000; req_valid[0] = 1'b1;
    @(negedge clk);
    check_eq("wd_ready_T", 32'(req_ready), 32'h1);
    push_exp(0, 32'h5710, 1'b0);
    after_pos();
    req_valid[0] = 1'b0;
    req_addr[AW +: AW] = 32'h4444; req_valid[1] = 1'b1;
    after_pos();
    req_valid[1] = 1'b0;
    drain();
    check_eq("wd_grants", 32'(grant_log.size()), 32'h1);
    check_eq("wd_accesses", 32'(n_acc), 32'h1);

    // reset in the second ACCESS cycle; requester 0 must win afterwards
    after_pos();
    wait_n = 10;
    req_addr[0 +: AW] = 32'h5000; req_valid[0] = 1'b1;
    @(negedge clk);
    check_eq("rs_ready_T", 32'(req_ready), 32'h1);
    after_pos();
    req_valid[0] = 1'b0;
    after_pos();
    check_eq("rs_enable_pre", 32'(ext_mem_enable), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rs_strobes", 32'({ext_mem_enable, ext_mem_read, ext_mem_write}), 32'h0);
    check_eq("rs_addr", ext_addr, 32'h0);
    wait_n = 0;
    req_addr[0 +: AW] = 32'h6000; req_addr[AW +: AW] = 32'h7000;
    req_valid = 2'b11;
    #1;
    check_eq("rs_handshake", 32'({rsp_valid, req_ready}), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_exp(0, 32'h7710, 1'b0);
    push_exp(1, 32'h8710, 1'b0);
    #1;
    check_eq("rs_first_grant", 32'(req_ready), 32'h1);
    after_pos();
    req_valid[0] = 1'b0;
    wait_grant(1);
    after_pos();
    req_valid[1] = 1'b0;
    drain();

`ifdef ARB_TIMEOUT_EN
    // timeout: memory never ready
    after_pos();
    wait_n = 1000;
    req_addr[0 +: AW] = 32'h8000; req_valid[0] = 1'b1;
    @(negedge clk);
    check_eq("to_ready_T", 32'(req_ready), 32'h1);
    push_exp(0, 32'h0, 1'b1);
    after_pos();
    req_valid[0] = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      check_eq($sformatf("to_enable_T%0d", k), 32'(ext_mem_enable), 32'h1);
    end
    @(negedge clk);
    check_eq("to_enable_drop", 32'(ext_mem_enable), 32'h0);
    check_eq("to_rsp", 32'(rsp_valid), 32'h1);
    wait_n = 0;
    after_pos();
    req_addr[0 +: AW] = 32'h9000; req_valid[0] = 1'b1;
    push_exp(0, 32'hA710, 1'b0);
    wait_grant(0);
    after_pos();
    req_valid[0] = 1'b0;
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
